// File: rtl/libhdl_count_sched.sv
// Round-robin scheduler sharing one down-counting delay timer among NUM_REQ requesters.
// Optional abort input enabled by defining LIBHDL_COUNT_SCHED_ABORT_EN.
module libhdl_count_sched #(
    parameter int NUM_REQ   = 4,
    parameter int COUNT_LEN = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ*COUNT_LEN-1:0]   i_ldval,
    input  logic                           i_ce,
`ifdef LIBHDL_COUNT_SCHED_ABORT_EN
    input  logic                           i_abort,
`endif
    output logic [NUM_REQ-1:0]             o_gnt,
    output logic [NUM_REQ-1:0]             o_done,
    output logic                           o_busy,
    output logic [COUNT_LEN-1:0]           o_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [COUNT_LEN-1:0] count_q, count_d;

    logic                 abort_w;
    logic [PTR_W-1:0]     win;
    logic [COUNT_LEN-1:0] win_ld;

`ifdef LIBHDL_COUNT_SCHED_ABORT_EN
    assign abort_w = i_abort;
`else
    assign abort_w = 1'b0;
`endif

    // Search starts just past the last owner so it ranks last next time.
    always_comb begin
        logic found;
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            automatic int idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx -= NUM_REQ;
            if (!found && i_req[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        win_ld = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (win == PTR_W'(k)) win_ld = i_ldval[k*COUNT_LEN +: COUNT_LEN];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (|i_req) begin
                    gnt_d   = NUM_REQ'(1) << win;
                    count_d = win_ld;
                    ptr_d   = win;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!i_req[ptr_q] || abort_w) begin
                    gnt_d   = '0;
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (i_ce && count_q == '0) begin
                    done_d  = NUM_REQ'(1) << ptr_q;
                    gnt_d   = '0;
                    state_d = S_DONE;
                end else if (i_ce) begin
                    count_d = count_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        o_gnt   = gnt_q;
        o_done  = done_q;
        o_count = count_q;
        o_busy  = (state_q == S_RUN) || (state_q == S_DONE);
    end

endmodule

// File: tb/tb_libhdl_count_sched.sv
// Directed bench for libhdl_count_sched: vector table plus multi-cycle corner sequences.
module tb_libhdl_count_sched;

    localparam int NR = 4;
    localparam int CL = 8;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic [NR-1:0]    i_req;
    logic [NR*CL-1:0] i_ldval;
    logic             i_ce;
`ifdef LIBHDL_COUNT_SCHED_ABORT_EN
    logic             i_abort;
`endif
    logic [NR-1:0]    o_gnt, o_done;
    logic             o_busy;
    logic [CL-1:0]    o_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    libhdl_count_sched #(.NUM_REQ(NR), .COUNT_LEN(CL)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_req),
        .i_ldval (i_ldval),
        .i_ce    (i_ce),
`ifdef LIBHDL_COUNT_SCHED_ABORT_EN
        .i_abort (i_abort),
`endif
        .o_gnt   (o_gnt),
        .o_done  (o_done),
        .o_busy  (o_busy),
        .o_count (o_count)
    );

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*CL-1:0] ld;
        logic             ce;
        logic [NR-1:0]    gnt;
        logic [NR-1:0]    done;
        logic             busy;
        logic [CL-1:0]    cnt;
    } vec_t;

    vec_t tbl[17];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [NR-1:0] g, input logic [NR-1:0] d,
                           input logic b, input logic [CL-1:0] c);
        chk({name, ".gnt"},   32'(o_gnt),   32'(g));
        chk({name, ".done"},  32'(o_done),  32'(d));
        chk({name, ".busy"},  32'(o_busy),  32'(b));
        chk({name, ".count"}, 32'(o_count), 32'(c));
    endtask

    function automatic vec_t mk(input logic [NR-1:0] r, input logic [NR*CL-1:0] l, input logic e,
                                input logic [NR-1:0] g, input logic [NR-1:0] d,
                                input logic b, input logic [CL-1:0] c);
        vec_t v;
        v.req = r; v.ld = l; v.ce = e; v.gnt = g; v.done = d; v.busy = b; v.cnt = c;
        return v;
    endfunction

    initial begin
        // inputs applied in cycle n; expected outputs are for cycle n+1
        tbl[0]  = mk(4'b0001, 32'h0000_0003, 1, 4'b0001, 4'b0000, 1, 8'd3);
        tbl[1]  = mk(4'b0001, 32'h0000_0003, 1, 4'b0001, 4'b0000, 1, 8'd2);
        tbl[2]  = mk(4'b0001, 32'h0000_0003, 1, 4'b0001, 4'b0000, 1, 8'd1);
        tbl[3]  = mk(4'b0001, 32'h0000_0003, 1, 4'b0001, 4'b0000, 1, 8'd0);
        tbl[4]  = mk(4'b0001, 32'h0000_0003, 1, 4'b0000, 4'b0001, 1, 8'd0);
        tbl[5]  = mk(4'b0000, 32'h0000_0003, 1, 4'b0000, 4'b0000, 0, 8'd0);
        tbl[6]  = mk(4'b0010, 32'h0000_0200, 1, 4'b0010, 4'b0000, 1, 8'd2);
        tbl[7]  = mk(4'b0010, 32'h0000_0200, 1, 4'b0010, 4'b0000, 1, 8'd1);
        tbl[8]  = mk(4'b1011, 32'h0000_0200, 0, 4'b0010, 4'b0000, 1, 8'd1);
        tbl[9]  = mk(4'b0010, 32'h0000_0200, 0, 4'b0010, 4'b0000, 1, 8'd1);
        tbl[10] = mk(4'b0010, 32'h0000_0200, 0, 4'b0010, 4'b0000, 1, 8'd1);
        tbl[11] = mk(4'b0010, 32'h0000_0200, 1, 4'b0010, 4'b0000, 1, 8'd0);
        tbl[12] = mk(4'b0010, 32'h0000_0200, 1, 4'b0000, 4'b0010, 1, 8'd0);
        tbl[13] = mk(4'b0000, 32'h0000_0200, 1, 4'b0000, 4'b0000, 0, 8'd0);
        tbl[14] = mk(4'b1000, 32'h0000_0000, 1, 4'b1000, 4'b0000, 1, 8'd0);
        tbl[15] = mk(4'b1000, 32'h0000_0000, 1, 4'b0000, 4'b1000, 1, 8'd0);
        tbl[16] = mk(4'b0000, 32'h0000_0000, 1, 4'b0000, 4'b0000, 0, 8'd0);

        i_rst_n = 1'b0;
        i_req   = '0;
        i_ldval = '0;
        i_ce    = 1'b0;
`ifdef LIBHDL_COUNT_SCHED_ABORT_EN
        i_abort = 1'b0;
`endif
        tick();
        tick();
        chk_all("reset", 4'b0000, 4'b0000, 0, 8'd0);
        i_rst_n = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            i_req   = tbl[i].req;
            i_ldval = tbl[i].ld;
            i_ce    = tbl[i].ce;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].done, tbl[i].busy, tbl[i].cnt);
        end

        // round robin: all four request D=1, each drops after its done
        i_ldval = 32'h0101_0101;
        i_ce    = 1'b1;
        i_req   = 4'b1111;
        for (int k = 0; k < NR; k++) begin
            tick();
            chk_all($sformatf("rr%0d.g", k), 4'(1 << k), 4'b0000, 1, 8'd1);
            tick();
            chk($sformatf("rr%0d.c0", k), 32'(o_count), 32'd0);
            tick();
            chk($sformatf("rr%0d.done", k), 32'(o_done), 32'(1 << k));
            i_req[k] = 1'b0;
            tick();
            chk($sformatf("rr%0d.idle", k), 32'(o_busy), 32'd0);
        end

        // req0 and req2 together after owner 3: 0 first, then 2
        i_req = 4'b0101;
        tick();
        chk("pair.first", 32'(o_gnt), 32'b0001);
        tick();
        tick();
        chk("pair.done0", 32'(o_done), 32'b0001);
        i_req = 4'b0100;
        tick();
        tick();
        chk("pair.second", 32'(o_gnt), 32'b0100);
        tick();
        tick();
        chk("pair.done2", 32'(o_done), 32'b0100);
        i_req = 4'b0000;
        tick();

        // D=255 on requester 0: done in cycle 257, never wraps
        i_ldval = 32'h0000_00FF;
        i_req   = 4'b0001;
        tick();
        chk("max.load", 32'(o_count), 32'd255);
        for (int c = 2; c <= 256; c++) tick();
        chk_all("max.last", 4'b0001, 4'b0000, 1, 8'd0);
        tick();
        chk_all("max.done", 4'b0000, 4'b0001, 1, 8'd0);
        i_req = 4'b0000;
        tick();
        chk("max.idle", 32'(o_busy), 32'd0);

        // withdrawal: req2 D=10 drops at count 5
        i_ldval = 32'h000A_0000;
        i_req   = 4'b0100;
        tick();
        chk_all("wd.load", 4'b0100, 4'b0000, 1, 8'd10);
        for (int c = 2; c <= 6; c++) tick();
        chk("wd.c5", 32'(o_count), 32'd5);
        i_req = 4'b0000;
        tick();
        chk_all("wd.end", 4'b0000, 4'b0000, 0, 8'd0);
        tick();
        chk("wd.nodone", 32'(o_done), 32'd0);

`ifdef LIBHDL_COUNT_SCHED_ABORT_EN
        i_req = 4'b0100;
        tick();
        chk_all("ab.load", 4'b0100, 4'b0000, 1, 8'd10);
        for (int c = 2; c <= 6; c++) tick();
        i_abort = 1'b1;
        tick();
        chk_all("ab.end", 4'b0000, 4'b0000, 0, 8'd0);
        i_abort = 1'b0;
        i_req   = 4'b0000;
        tick();
        chk("ab.nodone", 32'(o_done), 32'd0);
`endif

        // async reset mid-RUN at count 5
        i_ldval = 32'h0000_0008;
        i_req   = 4'b0001;
        tick();
        for (int c = 2; c <= 4; c++) tick();
        chk("rst.c5", 32'(o_count), 32'd5);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_all("rst.async", 4'b0000, 4'b0000, 0, 8'd0);
        i_req   = 4'b1111;
        i_ldval = 32'h0404_0404;
        #3;
        i_rst_n = 1'b1;
        tick();
        chk_all("rst.first", 4'b0001, 4'b0000, 1, 8'd4);
        i_req = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
